// File: rtl/mul_8_seq.sv
// 8x8 unsigned sequential multiplier: one shift-add step per clock through an
// 8-bit ripple adder, 9 busy cycles per product with a one-cycle done pulse.

module FA_8 (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       overflow
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
        assign c[i+1]   = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end

    // Unsigned carry-out of the MSB.
    assign overflow = c[8];
endmodule

module mul_8_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  mcand, hi, mq;
    logic [3:0]  count;

    logic [7:0]  add_sum;
    logic        add_cout;
    logic [7:0]  step_sum;
    logic        step_carry;
    logic [7:0]  hi_next, mq_next;

    FA_8 u_add (
        .in1      (hi),
        .in2      (mcand),
        .cin      (1'b0),
        .sum      (add_sum),
        .overflow (add_cout)
    );

    // Partial product is added only when the current multiplier bit is set.
    assign step_sum   = mq[0] ? add_sum  : hi;
    assign step_carry = mq[0] ? add_cout : 1'b0;
    assign hi_next    = {step_carry, step_sum[7:1]};
    assign mq_next    = {step_sum[0], mq[7:1]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == 4'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            hi      <= '0;
            mq      <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        hi    <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    hi    <= hi_next;
                    mq    <= mq_next;
                    count <= count + 4'd1;
                    if (count == 4'd7) product <= {hi_next, mq_next};
                end
                default: ;
            endcase
        end
    end
endmodule
